led_pwm_sequencer: RTL and testbench

//  Multi-channel LED driver for the board top levels, e.g. the Cmod A7 RGB0 LED and the user LEDs.

---
 rtl/led_pwm_pkg.sv | 18 +
 rtl/led_pwm_channel.sv | 111 +++++++++++
 rtl/led_pwm_sequencer.sv | 81 ++++++++
 tb/tb_led_pwm_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - mode and ramp-direction encodings shared by the LED PWM sequencer
package led_pwm_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_e;

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED channel: shadow/active config, breathe ramp FSM, PWM compare
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_we,
  input  logic [MODE_W-1:0]   i_mode,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_load,
  input  logic                i_step_tick,
  input  logic                i_blink_phase,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  localparam logic LED_OFF = (ACTIVE_LOW != 0);

  led_mode_e           r_shadow_mode, w_shadow_mode;
  logic [PWM_BITS-1:0] r_shadow_duty, w_shadow_duty;
  led_mode_e           r_mode, w_mode;
  logic [PWM_BITS-1:0] r_duty, w_duty;
  logic [PWM_BITS-1:0] r_level, w_level;
  ramp_dir_e           r_dir, w_dir;
  logic                r_led;
  logic [PWM_BITS-1:0] w_eff;
  logic                w_led;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow_mode <= MODE_OFF;
      r_shadow_duty <= '0;
      r_mode        <= MODE_OFF;
      r_duty        <= '0;
      r_level       <= '0;
      r_dir         <= DIR_UP;
      r_led         <= LED_OFF;
    end else begin
      r_shadow_mode <= w_shadow_mode;
      r_shadow_duty <= w_shadow_duty;
      r_mode        <= w_mode;
      r_duty        <= w_duty;
      r_level       <= w_level;
      r_dir         <= w_dir;
      r_led         <= w_led;
    end
  end

  // Load from the (already write-updated) shadow first, so a write in the load cycle
  // bypasses; the ramp step then acts on the freshly loaded state.
  always_comb begin
    w_shadow_mode = r_shadow_mode;
    w_shadow_duty = r_shadow_duty;
    w_mode        = r_mode;
    w_duty        = r_duty;
    w_level       = r_level;
    w_dir         = r_dir;
    if (i_we) begin
      w_shadow_mode = led_mode_e'(i_mode);
      w_shadow_duty = i_duty;
    end
    if (i_load) begin
      w_mode = w_shadow_mode;
      w_duty = w_shadow_duty;
      if (w_shadow_mode != r_mode) begin
        w_level = '0;
        w_dir   = DIR_UP;
      end else if (w_mode == MODE_BREATHE && r_level > w_duty) begin
        w_level = w_duty;
        w_dir   = DIR_DOWN;
      end
    end
    if (i_step_tick && w_mode == MODE_BREATHE) begin
      case (w_dir)
        DIR_UP: begin
          if (w_level < w_duty) begin
            w_level = w_level + 1'b1;
            if (w_level == w_duty) w_dir = DIR_DOWN;
          end else begin
            w_dir = DIR_DOWN;
          end
        end
        default: begin
          if (w_level > '0) begin
            w_level = w_level - 1'b1;
            if (w_level == '0) w_dir = DIR_UP;
          end else begin
            w_dir = DIR_UP;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_eff = '0;
    case (r_mode)
      MODE_STATIC:  w_eff = r_duty;
      MODE_BLINK:   w_eff = i_blink_phase ? r_duty : '0;
      MODE_BREATHE: w_eff = r_level;
      default:      w_eff = '0;
    endcase
    w_led = (i_pwm_cnt < w_eff) ^ LED_OFF;
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pwm_sequencer.sv
// rtl/led_pwm_sequencer.sv - multi-channel PWM LED driver with OFF/STATIC/BLINK/BREATHE modes
module led_pwm_sequencer
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int STEP_DIV    = 12000,
  parameter int BLINK_STEPS = 250,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic                period_start
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int BLINK_W = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

  logic [PRESC_W-1:0]  r_presc;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_period_start;
  logic                w_step_tick;
  logic                w_pwm_max;
  logic [CHANNELS-1:0] w_ch_we;

  assign w_step_tick = (r_presc == PRESC_W'(STEP_DIV - 1));
  assign w_pwm_max   = &r_pwm_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc        <= '0;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_pwm_cnt      <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_step_tick ? '0 : r_presc + 1'b1;
      r_pwm_cnt      <= r_pwm_cnt + 1'b1;
      r_period_start <= w_pwm_max;
      if (w_step_tick) begin
        if (r_blink_cnt == BLINK_W'(BLINK_STEPS - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign period_start = r_period_start;

  // Out-of-range channel indices match no channel and are silently dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_ch_we[g] = cfg_we && (cfg_ch == 4'(g));

    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_channel (
      .i_clk         (CLK),
      .i_reset       (RESET),
      .i_we          (w_ch_we[g]),
      .i_mode        (cfg_mode),
      .i_duty        (cfg_duty),
      .i_load        (w_pwm_max),
      .i_step_tick   (w_step_tick),
      .i_blink_phase (r_blink_phase),
      .i_pwm_cnt     (r_pwm_cnt),
      .o_led         (led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// tb/tb_led_pwm_sequencer.sv - directed self-checking bench for led_pwm_sequencer
module tb_led_pwm_sequencer;
  import led_pwm_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       cfg_we;
  logic [3:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [2:0] led;
  logic       period_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_pwm_sequencer #(
    .CHANNELS    (3),
    .PWM_BITS    (4),
    .STEP_DIV    (2),
    .BLINK_STEPS (3),
    .ACTIVE_LOW  (1)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .led          (led),
    .period_start (period_start)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycles since the last reset edge; equals the DUT pwm_cnt/prescaler phase origin.
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_duty = duty;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic sync_period();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (period_start) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL sync_period: period_start not seen within 40 clocks, got 0 required 1");
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    n_checks++;
    if (led !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_led: got %b required 111", led);
    end
    n_checks++;
    if (period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_period_start: got %b required 0", period_start);
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_checks++;
      if (led !== 3'b111) begin
        n_fail++;
        $display("FAIL idle_led k=%0d: got %b required 111", k, led);
      end
      n_checks++;
      if (period_start !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL idle_period_start k=%0d: got %b required %b", k, period_start, (k % 16) == 0);
      end
    end
  endtask

  task automatic test_static();
    logic [3:0] duties [3] = '{4'd5, 4'd0, 4'd15};
    for (int d = 0; d < 3; d++) begin
      int lit = 0;
      sync_period();
      cfg_write(4'd0, MODE_STATIC, duties[d]);
      sync_period();
      for (int r = 0; r < 16; r++) begin
        tick();
        if (led[0] === 1'b0) lit++;
        n_checks++;
        if (led[0] !== ((r < int'(duties[d])) ? 1'b0 : 1'b1)) begin
          n_fail++;
          $display("FAIL static_led0 duty=%0d cnt=%0d: got %b required %b", duties[d], r, led[0],
                   (r < int'(duties[d])) ? 1'b0 : 1'b1);
        end
        n_checks++;
        if (led[2:1] !== 2'b11) begin
          n_fail++;
          $display("FAIL static_other duty=%0d cnt=%0d: got %b required 11", duties[d], r, led[2:1]);
        end
      end
      n_checks++;
      if (lit != int'(duties[d])) begin
        n_fail++;
        $display("FAIL static_count duty=%0d: got %0d lit clocks required %0d", duties[d], lit, duties[d]);
      end
    end
  endtask

  task automatic test_blink();
    sync_period();
    cfg_write(4'd0, MODE_OFF, 4'd0);
    cfg_write(4'd1, MODE_BLINK, 4'd15);
    sync_period();
    for (int r = 0; r < 48; r++) begin
      int  t;
      bit  exp_lit;
      tick();
      t = cyc - 1;
      exp_lit = (((t / 6) % 2) == 1) && ((t % 16) < 15);
      n_checks++;
      if (led[1] !== !exp_lit) begin
        n_fail++;
        $display("FAIL blink_led1 t=%0d: got %b required %b", t, led[1], !exp_lit);
      end
      n_checks++;
      if (led[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL blink_led0_off t=%0d: got %b required 1", t, led[0]);
      end
    end
  endtask

  task automatic test_breathe();
    int seq [6] = '{0, 1, 2, 3, 2, 1};
    sync_period();
    cfg_write(4'd1, MODE_OFF, 4'd0);
    cfg_write(4'd2, MODE_BREATHE, 4'd3);
    sync_period();
    cfg_we   = 1'b1;
    cfg_ch   = 4'd2;
    cfg_mode = MODE_BREATHE;
    cfg_duty = 4'd1;
    for (int rel = 0; rel < 48; rel++) begin
      int level;
      bit exp_led;
      tick();
      cfg_we = 1'b0;
      if (rel < 16) level = seq[((rel / 2) + 1) % 6];
      else          level = ((rel - 16) / 2) % 2;
      exp_led = !((rel % 16) < level);
      n_checks++;
      if (led[2] !== exp_led) begin
        n_fail++;
        $display("FAIL breathe_led2 rel=%0d level=%0d: got %b required %b", rel, level, led[2], exp_led);
      end
    end
  endtask

  task automatic test_config_edges();
    int lit;
    cfg_write(4'd2, MODE_OFF, 4'd0);
    cfg_write(4'd7, MODE_STATIC, 4'd15);
    sync_period();
    for (int r = 0; r < 16; r++) begin
      tick();
      n_checks++;
      if (led !== 3'b111) begin
        n_fail++;
        $display("FAIL bad_channel_write cnt=%0d: got %b required 111", r, led);
      end
    end
    cfg_write(4'd0, MODE_STATIC, 4'd15);
    cfg_write(4'd0, MODE_STATIC, 4'd3);
    sync_period();
    lit = 0;
    for (int r = 0; r < 16; r++) begin
      tick();
      if (led[0] === 1'b0) lit++;
    end
    n_checks++;
    if (lit != 3) begin
      n_fail++;
      $display("FAIL last_write_wins: got %0d lit clocks required 3", lit);
    end
    repeat (15) tick();
    cfg_write(4'd0, MODE_STATIC, 4'd9);
    n_checks++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_alignment: period_start got %b required 1", period_start);
    end
    lit = 0;
    for (int r = 0; r < 16; r++) begin
      tick();
      if (led[0] === 1'b0) lit++;
    end
    n_checks++;
    if (lit != 9) begin
      n_fail++;
      $display("FAIL load_cycle_bypass: got %0d lit clocks required 9", lit);
    end
  endtask

  task automatic test_reset_mid_breathe();
    cfg_write(4'd2, MODE_BREATHE, 4'd3);
    sync_period();
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++;
    if (led !== 3'b111) begin
      n_fail++;
      $display("FAIL midreset_led: got %b required 111", led);
    end
    n_checks++;
    if (period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_period_start: got %b required 0", period_start);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_checks++;
      if (led !== 3'b111) begin
        n_fail++;
        $display("FAIL midreset_modes_off k=%0d: got %b required 111", k, led);
      end
      n_checks++;
      if (period_start !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL midreset_pwm_restart k=%0d: got %b required %b", k, period_start, (k % 16) == 0);
      end
    end
  endtask

  initial begin
    RESET    = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = 4'd0;
    cfg_mode = 2'd0;
    cfg_duty = 4'd0;
    test_reset();
    test_static();
    test_blink();
    test_breathe();
    test_config_edges();
    test_reset_mid_breathe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
